// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and the operand patterns used for signed-overflow detection.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam logic [MD_XLEN-1:0] INT_MIN  = {1'b1, {(MD_XLEN-1){1'b0}}};
  localparam logic [MD_XLEN-1:0] ALL_ONES = {MD_XLEN{1'b1}};

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative datapath: shift-add multiplier and restoring divider sharing one
// hi/lo register pair, plus sign fix-up and the result register.
import muldiv_pkg::*;

module muldiv_datapath #(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_fix,
  input  logic            i_specLoad,
  input  logic [XLEN-1:0] i_specVal,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_opA,
  input  logic [XLEN-1:0] i_opB,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_mag;
  logic              r_negQ;
  logic              r_negR;
  logic [XLEN-1:0]   r_result;

  logic              w_isDiv;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prodS;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fixVal;

  assign w_isDiv = i_funct3[2];

  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (i_funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_sa = i_opA[XLEN-1];
        w_sb = i_opB[XLEN-1];
      end
      F3_MULHSU: w_sa = i_opA[XLEN-1];
      default: ;
    endcase
  end

  assign w_absA = w_sa ? -i_opA : i_opA;
  assign w_absB = w_sb ? -i_opB : i_opB;

  // Multiply: hi accumulates the multiplicand whenever the multiplier LSB in lo is set
  assign w_addend = r_lo[0] ? r_mag : '0;
  assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

  // Divide: the guard bit in w_shift/w_diff tells whether the trial subtract went negative
  assign w_shift  = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_mag};

  assign w_prod   = {r_hi, r_lo};
  assign w_prodS  = r_negQ ? -w_prod : w_prod;
  assign w_quot   = r_negQ ? -r_lo : r_lo;
  assign w_rem    = r_negR ? -r_hi : r_hi;

  always_comb begin
    w_fixVal = '0;
    case (i_funct3)
      F3_MUL:                       w_fixVal = w_prodS[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fixVal = w_prodS[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_fixVal = w_quot;
      F3_REM, F3_REMU:              w_fixVal = w_rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_mag    <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_result <= '0;
    end else begin
      if (i_load) begin
        r_hi   <= '0;
        r_lo   <= w_isDiv ? w_absA : w_absB;
        r_mag  <= w_isDiv ? w_absB : w_absA;
        r_negQ <= (w_sa ^ w_sb) && (i_opB != '0);
        r_negR <= w_sa;
      end else if (i_step) begin
        if (w_isDiv) begin
          r_hi <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
      end
      if (i_fix) begin
        r_result <= w_fixVal;
      end else if (i_specLoad) begin
        r_result <= i_specVal;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/muldiv_seq_unit.sv
// RV32M multi-cycle sequencer: handshake FSM, special-case detection and control
// of muldiv_datapath. Optional macro MULDIV_FAST_ZERO_EN short-cuts zero operands.
import muldiv_pkg::*;

module muldiv_seq_unit #(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  state_e          r_state;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_opA;
  logic [XLEN-1:0] r_opB;
  logic [CNT_W-1:0] r_cnt;
  logic            r_ready;
  logic            r_resultValid;
  logic            r_busy;

  logic            w_isDiv;
  logic            w_divZero;
  logic            w_overflow;
  logic            w_fastZero;
  logic            w_special;
  logic [XLEN-1:0] w_specVal;
  logic            w_load;
  logic            w_specLoad;
  logic            w_step;
  logic            w_fix;

  assign w_isDiv    = r_funct3[2];
  assign w_divZero  = w_isDiv && (r_opB == '0);
  assign w_overflow = ((r_funct3 == F3_DIV) || (r_funct3 == F3_REM)) &&
                      (r_opA == XLEN'(INT_MIN)) && (r_opB == XLEN'(ALL_ONES));

`ifdef MULDIV_FAST_ZERO_EN
  assign w_fastZero = w_isDiv ? ((r_opA == '0) && (r_opB != '0))
                              : ((r_opA == '0) || (r_opB == '0));
`else
  assign w_fastZero = 1'b0;
`endif

  assign w_special = w_divZero || w_overflow || w_fastZero;

  // Divide-by-zero takes priority; fast-zero results fall through to 0
  always_comb begin
    w_specVal = '0;
    if (w_divZero) begin
      w_specVal = r_funct3[1] ? r_opA : '1;
    end else if (w_overflow) begin
      w_specVal = r_funct3[1] ? '0 : XLEN'(INT_MIN);
    end
  end

  assign w_load     = (r_state == ST_PREP) && !flush_i && !w_special;
  assign w_specLoad = (r_state == ST_PREP) && !flush_i && w_special;
  assign w_step     = (r_state == ST_CALC) && !flush_i;
  assign w_fix      = (r_state == ST_FIX) && !flush_i;

  // A flush anywhere past IDLE abandons the op; in DONE it also drops the held result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_funct3      <= '0;
      r_opA         <= '0;
      r_opB         <= '0;
      r_cnt         <= '0;
      r_ready       <= 1'b1;
      r_resultValid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i && r_ready && !flush_i) begin
            r_funct3 <= funct3_i;
            r_opA    <= op_a_i;
            r_opB    <= op_b_i;
            r_state  <= ST_PREP;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ST_PREP: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_special) begin
            r_state       <= ST_DONE;
            r_resultValid <= 1'b1;
          end else begin
            r_state <= ST_CALC;
            r_cnt   <= '0;
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(XLEN - 1)) begin
            r_state <= ST_FIX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state       <= ST_DONE;
            r_resultValid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (flush_i || result_ready_i) begin
            r_state       <= ST_IDLE;
            r_resultValid <= 1'b0;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_resultValid <= 1'b0;
          r_ready       <= 1'b1;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_fix      (w_fix),
    .i_specLoad (w_specLoad),
    .i_specVal  (w_specVal),
    .i_funct3   (r_funct3),
    .i_opA      (r_opA),
    .i_opB      (r_opB),
    .o_result   (result_o)
  );

  assign ready_o        = r_ready;
  assign result_valid_o = r_resultValid;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed self-checking bench for muldiv_seq_unit: hand-computed RV32M results,
// latency, flush/reset behaviour and result hold under back-pressure.
import muldiv_pkg::*;

module tb_muldiv_seq_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int checkCount = 0;
  int passCount  = 0;
  int lat;
  bit readyLow;
  bit sawValid;
  bit fastZero;

  muldiv_seq_unit dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .funct3_i       (funct3_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Presents one request; returns at the negedge right after the accept edge
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    valid_i  = 1'b1;
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    @(negedge clk_i);
    valid_i  = 1'b0;
  endtask

  task automatic waitResult();
    lat      = 0;
    readyLow = 1'b1;
    while (!result_valid_o && lat < 60) begin
      if (ready_o) readyLow = 1'b0;
      @(negedge clk_i);
      lat++;
    end
    if (ready_o) readyLow = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input bit shortPath);
    applyStimulus(f3, a, b);
    waitResult();
    checkOutput({tag, ".valid"}, {31'b0, result_valid_o}, 32'd1);
    checkOutput({tag, ".result"}, result_o, expRes);
    if (shortPath)
      checkOutput({tag, ".latShort"}, {31'b0, (lat >= 1 && lat <= 2)}, 32'd1);
    else
      checkOutput({tag, ".lat"}, 32'(lat), 32'd34);
    checkOutput({tag, ".readyLow"}, {31'b0, readyLow}, 32'd1);
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    checkOutput({tag, ".idle"}, {30'b0, ready_o, result_valid_o}, 32'b10);
  endtask

  initial begin
`ifdef MULDIV_FAST_ZERO_EN
    fastZero = 1'b1;
`else
    fastZero = 1'b0;
`endif
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; funct3_i = '0;
    op_a_i = '0; op_b_i = '0; result_ready_i = 1'b0;
    #12;
    checkOutput("rst.ready", {31'b0, ready_o}, 32'd1);
    checkOutput("rst.valid", {31'b0, result_valid_o}, 32'd0);
    checkOutput("rst.result", result_o, 32'd0);
    checkOutput("rst.busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] arithmetic vectors");
    runOp("mul7xm3",  F3_MUL,    32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    runOp("mulhMin",  F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    runOp("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    runOp("mulhu",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    runOp("divM7by2", F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    runOp("remM7by2", F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    runOp("divu100",  F3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0);
    runOp("remu100",  F3_REMU,   32'd100,        32'd7,         32'd2,         1'b0);

    $display("[TB] special cases");
    runOp("div5by0",  F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
    runOp("rem5by0",  F3_REM,    32'd5,          32'd0,         32'd5,         1'b1);
    runOp("divOvf",   F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    runOp("remOvf",   F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1);
    runOp("mul0x5",   F3_MUL,    32'd0,          32'd5,         32'd0,         fastZero);
    runOp("div0by5",  F3_DIV,    32'd0,          32'd5,         32'd0,         fastZero);

    $display("[TB] flush during CALC");
    applyStimulus(F3_DIVU, 32'd1000, 32'd3);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk_i);
      lat++;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flushCalc.idle", {30'b0, ready_o, busy_o}, 32'b10);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid_o) sawValid = 1'b1;
      @(negedge clk_i);
    end
    checkOutput("flushCalc.noValid", {31'b0, sawValid}, 32'd0);
    runOp("mul3x4", F3_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

    $display("[TB] flush with valid in IDLE");
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; funct3_i = F3_MUL; op_a_i = 32'd9; op_b_i = 32'd9;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    checkOutput("flushIdle.notTaken", {30'b0, ready_o, busy_o}, 32'b10);
    checkOutput("flushIdle.resultKept", result_o, 32'd12);

    $display("[TB] result hold and flush in DONE");
    applyStimulus(F3_DIVU, 32'd100, 32'd7);
    waitResult();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.valid", {31'b0, result_valid_o}, 32'd1);
      checkOutput("hold.result", result_o, 32'd14);
      @(negedge clk_i);
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("flushDone.idle", {30'b0, ready_o, result_valid_o}, 32'b10);
    checkOutput("flushDone.resultHeld", result_o, 32'd14);

    $display("[TB] reset mid-CALC");
    applyStimulus(F3_MUL, 32'd6, 32'd7);
    repeat (10) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checkOutput("midRst.ready", {31'b0, ready_o}, 32'd1);
    checkOutput("midRst.valid", {31'b0, result_valid_o}, 32'd0);
    checkOutput("midRst.result", result_o, 32'd0);
    checkOutput("midRst.busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    runOp("mul6x7", F3_MUL, 32'd6, 32'd7, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting beside the single-cycle ALU in the execute stage. It accepts one operation via a valid/ready handshake and runs an iterative shift-add multiply or restoring divide under FSM control. It returns the result via a valid/ready handshake, and the pipeline stalls on it while busy.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
clk_i  input  1  system clock, rising edge.
rst_ni  input  1  asynchronous reset, active low.
flush_i  input  1  pipeline flush; aborts the in-flight op.
valid_i  input  1  request valid.
ready_o  output  1  unit can accept a request.
funct3_i  input  3  M-extension funct3 (000 MUL … 111 REMU).
op_a_i  input  XLEN  rs1 operand.
op_b_i  input  XLEN  rs2 operand.
result_valid_o  output  1  result available.
result_ready_i  input  1  consumer accepts the result.
result_o  output  XLEN  result data.
busy_o  output  1  high in any state except IDLE; drives the stall.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, ready_o=1, result_valid_o=0, result_o=0, busy_o=0, counter=0, all internal registers 0.
- States:
  - IDLE: ready_o=1. On valid_i&&ready_o&&!flush_i, latch funct3_i and the operands, then go to PREP.
  - PREP (1 cycle): compute magnitudes and the sign of the result. Signedness per op: MULH both signed; MULHSU a signed, b unsigned; DIV/REM both signed; others unsigned. Special cases go directly to DONE.
  - CALC: one iteration per cycle, counter from 0 to XLEN-1. On counter==XLEN-1, go to FIX.
  - FIX (1 cycle): apply sign negation, select low/high product or quotient/remainder, register into result_o, go to DONE.
  - DONE: result_valid_o=1, result_o stable. On result_ready_i, go to IDLE the same edge.
- Normal latency: accept edge → PREP → XLEN CALC cycles → FIX → result_valid_o high XLEN+2 cycles after the accept edge (34 for XLEN=32).
- Multiply: 2·XLEN-bit accumulator, shift-add. MUL returns the low half; MULH/MULHSU/MULHU return the high half of the correctly signed 2·XLEN product.
- Divide: restoring algorithm; XLEN-bit remainder register plus one guard bit; quotient shifts in from the LSB.
  - Remainder sign follows the dividend.
  - Quotient is negative iff the operand signs differ and the divisor is nonzero.
- Special cases, decided in PREP, go to DONE at PREP+1 with no CALC:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (op_a=0x8000_0000, op_b=all ones): DIV → 0x8000_0000; REM → 0.
- Flush:
  - flush_i in PREP/CALC/FIX returns to IDLE next edge; result_valid_o is never raised for that op.
  - flush_i in DONE drops result_valid_o next edge and returns to IDLE.
  - flush_i with valid_i in IDLE: the request is not accepted.
- ready_o is 0 outside IDLE; no back-to-back accept while a result is held.
- result_o holds its last value after DONE until the next FIX or special-case load.
- Reset mid-operation: immediate return to the reset values above.

Optional Feature:
MULDIV_FAST_ZERO_EN.
- Defined: in PREP, a MUL-class op with op_a==0 or op_b==0 → result 0. A DIV-class op with op_a==0 and op_b!=0 → quotient 0, remainder 0. Both go to DONE at PREP+1 (latency 2).
- Undefined: these operands take the full XLEN+2 path with identical results.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F3_MUL … F3_REMU).
  - FSM state encoding (IDLE, PREP, CALC, FIX, DONE).
  - Helper constants for overflow detection (INT_MIN pattern, all-ones).
- One sub-module is natural: muldiv_datapath. It holds the accumulator/remainder/quotient registers and the add/sub logic, controlled by step/load/fix strobes from the FSM in muldiv_seq_unit.

Test Plan:
- MUL 7×(−3) (0x7, 0xFFFF_FFFD) → result_o=0xFFFF_FFEB; result_valid_o at cycle 34; ready_o low cycles 1–34.
- MULH 0x8000_0000×0x8000_0000 → 0x4000_0000; MULHSU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFF; MULHU same operands → 0xFFFF_FFFE.
- DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFF_FFFF and REM 5/0 → 5, each at latency 2. DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM same operands → 0.
- Start DIVU, assert flush_i at cycle 10 → IDLE at cycle 11, result_valid_o never high. New MUL 3×4 then accepted → 12.
- Hold result_ready_i=0 for 5 cycles after DONE → result_valid_o and result_o stable. Drop rst_ni mid-CALC → all outputs at reset values immediately. With MULDIV_FAST_ZERO_EN, MUL 0×5 → 0 at cycle 2.
